// File: rtl/hub75_rx_pkg.sv
// Shared HUB75 receiver definitions: default geometry, pixel layout and the
// framebuffer write record.
package hub75_rx_pkg;

  localparam int unsigned DEF_COLS     = 64;
  localparam int unsigned DEF_ROW_BITS = 5;

  // Colour bit order on the wire is {B,G,R}
  typedef struct packed {
    logic b;
    logic g;
    logic r;
  } rgb_t;

  typedef struct packed {
    rgb_t rgb1;
    rgb_t rgb0;
  } pix_t;

  typedef struct packed {
    logic [DEF_ROW_BITS-1:0]      row;
    logic [$clog2(DEF_COLS)-1:0]  col;
    pix_t                         data;
  } fb_wr_t;

  typedef enum logic {
    WR_IDLE,
    WR_WRITE
  } wr_state_e;

endpackage

// File: rtl/hub75_rx_sync.sv
// Multi-stage input synchroniser with rising-edge detect on the last two
// synchronised samples.
module hub75_rx_sync #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) stage_q[i] <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
      prev_q <= stage_q[STAGES-1];
    end
  end

  assign q_o    = stage_q[STAGES-1];
  assign rise_o = stage_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 link receiver: rebuilds each shifted dual-chain line and replays it
// as one framebuffer write per clock after the latch.
module hub75_rx
  import hub75_rx_pkg::*;
#(
  parameter int unsigned COLS        = DEF_COLS,
  parameter int unsigned ROW_BITS    = DEF_ROW_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              sclk,
  input  logic                              latch,
  input  logic                              blank,
  input  logic [ROW_BITS-1:0]               addry,
  input  logic [2:0]                        rgb0,
  input  logic [2:0]                        rgb1,
  output logic                              fb_we,
  output logic [ROW_BITS+$clog2(COLS)-1:0]  fb_addr,
  output logic [5:0]                        fb_data,
  output logic                              line_done,
  output logic                              frame_start,
  output logic                              err_overrun,
  output logic                              err_count,
  output logic                              blanked
);

  localparam int unsigned           CW       = $clog2(COLS);
  localparam int unsigned           MW       = ROW_BITS + 7;
  localparam logic [CW:0]           FULL     = (CW+1)'(COLS);
  localparam logic [CW-1:0]         LAST_COL = CW'(COLS - 1);
  localparam logic [ROW_BITS-1:0]   LAST_ROW = '1;

  logic [1:0]    ctrl_level_unused, ctrl_rise;
  logic [MW-1:0] mon_s, mon_rise_unused;
  logic          sclk_rise, latch_rise;
  logic [ROW_BITS-1:0] addr_s;
  pix_t          pix_s;

  hub75_rx_sync #(.WIDTH(2), .STAGES(SYNC_STAGES), .RST_VAL(2'b00)) u_sync_ctrl (
    .clk    (clk),
    .reset  (reset),
    .d_i    ({latch, sclk}),
    .q_o    (ctrl_level_unused),
    .rise_o (ctrl_rise)
  );

  // blank rides with the data bus; it only needs the same delay, not an edge
  hub75_rx_sync #(.WIDTH(MW), .STAGES(SYNC_STAGES), .RST_VAL({1'b1, {(MW-1){1'b0}}})) u_sync_data (
    .clk    (clk),
    .reset  (reset),
    .d_i    ({blank, addry, rgb1, rgb0}),
    .q_o    (mon_s),
    .rise_o (mon_rise_unused)
  );

  assign sclk_rise  = ctrl_rise[0];
  assign latch_rise = ctrl_rise[1];
  assign addr_s     = mon_s[MW-2:6];
  assign pix_s      = pix_t'(mon_s[5:0]);

  wr_state_e           state_q, state_d;
  logic [CW:0]         col_cnt_q, col_cnt_d;
  logic [CW-1:0]       wcol_q, wcol_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic                row_valid_q, row_valid_d;
  logic                fs_pend_q, fs_pend_d;
  logic                done_pend_q, done_pend_d;
  pix_t                line_buf_q [COLS];
  pix_t                line_buf_d [COLS];
  pix_t                out_buf_q  [COLS];
  logic                accept;
  logic                fb_we_q, fb_we_d;
  logic [ROW_BITS+CW-1:0] fb_addr_q, fb_addr_d;
  logic [5:0]          fb_data_q, fb_data_d;
  logic                line_done_q, line_done_d;
  logic                frame_start_q, frame_start_d;
  logic                err_count_q, err_count_d;
  logic                err_overrun_q, err_overrun_d;

  // Shift is applied before the commit so a coincident pixel joins the latched line
  always_comb begin
    line_buf_d    = line_buf_q;
    col_cnt_d     = col_cnt_q;
    state_d       = state_q;
    wcol_d        = wcol_q;
    row_d         = row_q;
    row_valid_d   = row_valid_q;
    fs_pend_d     = fs_pend_q;
    done_pend_d   = 1'b0;
    accept        = 1'b0;
    err_count_d   = err_count_q;
    err_overrun_d = err_overrun_q;
    fb_we_d       = 1'b0;
    fb_addr_d     = fb_addr_q;
    fb_data_d     = fb_data_q;
    frame_start_d = 1'b0;
    line_done_d   = done_pend_q;

    if (sclk_rise) begin
      if (col_cnt_q < FULL) begin
        line_buf_d[col_cnt_q[CW-1:0]] = pix_s;
        col_cnt_d = col_cnt_q + 1'b1;
      end else begin
        err_count_d = 1'b1;
      end
    end

    if (latch_rise) begin
      if (state_q == WR_IDLE) begin
        accept      = 1'b1;
        if (col_cnt_d != FULL) err_count_d = 1'b1;
        row_d       = addr_s;
        row_valid_d = 1'b1;
        fs_pend_d   = (addr_s == '0) && row_valid_q && (row_q == LAST_ROW);
        wcol_d      = '0;
        state_d     = WR_WRITE;
      end else begin
        err_overrun_d = 1'b1;
      end
      col_cnt_d = '0;
    end

    if (state_q == WR_WRITE) begin
      fb_we_d       = 1'b1;
      fb_addr_d     = {row_q, wcol_q};
      fb_data_d     = out_buf_q[wcol_q];
      frame_start_d = fs_pend_q && (wcol_q == '0);
      wcol_d        = wcol_q + 1'b1;
      if (wcol_q == LAST_COL) begin
        state_d     = WR_IDLE;
        done_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WR_IDLE;
      col_cnt_q     <= '0;
      wcol_q        <= '0;
      row_q         <= '0;
      row_valid_q   <= 1'b0;
      fs_pend_q     <= 1'b0;
      done_pend_q   <= 1'b0;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_data_q     <= '0;
      line_done_q   <= 1'b0;
      frame_start_q <= 1'b0;
      err_count_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_cnt_q     <= col_cnt_d;
      wcol_q        <= wcol_d;
      row_q         <= row_d;
      row_valid_q   <= row_valid_d;
      fs_pend_q     <= fs_pend_d;
      done_pend_q   <= done_pend_d;
      fb_we_q       <= fb_we_d;
      fb_addr_q     <= fb_addr_d;
      fb_data_q     <= fb_data_d;
      line_done_q   <= line_done_d;
      frame_start_q <= frame_start_d;
      err_count_q   <= err_count_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    line_buf_q <= line_buf_d;
    if (accept) out_buf_q <= line_buf_d;
  end

  assign fb_we       = fb_we_q;
  assign fb_addr     = fb_addr_q;
  assign fb_data     = fb_data_q;
  assign line_done   = line_done_q;
  assign frame_start = frame_start_q;
  assign err_overrun = err_overrun_q;
  assign err_count   = err_count_q;
  assign blanked     = mon_s[MW-1];

endmodule

// File: tb/tb_hub75_rx.sv
// Scoreboard bench for hub75_rx: a line-level model queues expected writes,
// a monitor pops and compares them as the DUT emits fb_we.
module tb_hub75_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        latch = 1'b0;
  logic        blank = 1'b1;
  logic [4:0]  addry = '0;
  logic [2:0]  rgb0 = '0;
  logic [2:0]  rgb1 = '0;
  logic        fb_we;
  logic [10:0] fb_addr;
  logic [5:0]  fb_data;
  logic        line_done, frame_start, err_overrun, err_count, blanked;

  hub75_rx #(.COLS(64), .ROW_BITS(5), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .sclk        (sclk),
    .latch       (latch),
    .blank       (blank),
    .addry       (addry),
    .rgb0        (rgb0),
    .rgb1        (rgb1),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .line_done   (line_done),
    .frame_start (frame_start),
    .err_overrun (err_overrun),
    .err_count   (err_count),
    .blanked     (blanked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;

  typedef struct {
    logic [10:0] addr;
    logic [5:0]  data;
    bit          fs;
    bit          last;
  } wr_t;

  wr_t exp_q[$];
  bit  in_line  = 1'b0;
  bit  exp_done = 1'b0;

  // line-level reference state
  logic [5:0] m_line [64];
  int         m_cnt = 0;
  bit         m_prev_valid = 1'b0;
  int         m_prev_row = 0;
  bit         m_err_count = 1'b0;
  bit         m_err_overrun = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic model_shift(input logic [5:0] px);
    if (m_cnt < 64) begin
      m_line[m_cnt] = px;
      m_cnt++;
    end else begin
      m_err_count = 1'b1;
    end
  endtask

  task automatic model_commit(input int row, input bit dropped);
    if (dropped) begin
      m_err_overrun = 1'b1;
    end else begin
      if (m_cnt != 64) m_err_count = 1'b1;
      for (int k = 0; k < 64; k++) begin
        wr_t w;
        w.addr = 11'(row * 64 + k);
        w.data = m_line[k];
        w.fs   = (k == 0) && (row == 0) && m_prev_valid && (m_prev_row == 31);
        w.last = (k == 63);
        exp_q.push_back(w);
      end
      m_prev_valid = 1'b1;
      m_prev_row   = row;
    end
    m_cnt = 0;
  endtask

  task automatic drive_shift(input logic [5:0] px);
    {rgb1, rgb0} = px;
    model_shift(px);
    repeat (2) @(negedge clk);
    sclk = 1'b1;
    repeat (2) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic latch_line(input int row, input bit dropped);
    addry = 5'(row);
    model_commit(row, dropped);
    latch = 1'b1;
    repeat (2) @(negedge clk);
    latch = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic shift_and_latch(input logic [5:0] px, input int row);
    {rgb1, rgb0} = px;
    addry = 5'(row);
    model_shift(px);
    model_commit(row, 1'b0);
    repeat (2) @(negedge clk);
    sclk  = 1'b1;
    latch = 1'b1;
    repeat (2) @(negedge clk);
    sclk  = 1'b0;
    latch = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_done) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(n >= 400), 32'd0);
  endtask

  task automatic check_flags(input string nm);
    chk({nm, "_err_count"}, 32'(err_count), 32'(m_err_count));
    chk({nm, "_err_overrun"}, 32'(err_overrun), 32'(m_err_overrun));
  endtask

  task automatic send_line(input int row, input int n);
    for (int i = 0; i < n; i++) drive_shift(6'($urandom));
    latch_line(row, 1'b0);
    drain();
  endtask

  // Monitor: every write must match the head of the queue, lines are gap-free,
  // line_done follows the last write by one cycle.
  always @(negedge clk) begin
    wr_t e;
    bit  done_now;
    done_now = exp_done;
    exp_done = 1'b0;
    if (line_done || done_now) chk("line_done", 32'(line_done), 32'(done_now));
    if (fb_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h, no write expected", fb_addr, fb_data);
      end else begin
        e = exp_q.pop_front();
        chk("fb_addr", 32'(fb_addr), 32'(e.addr));
        chk("fb_data", 32'(fb_data), 32'(e.data));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        wr_seen++;
        in_line  = !e.last;
        exp_done = e.last;
      end
    end else begin
      if (frame_start) chk("frame_start_idle", 32'(frame_start), 32'd0);
      if (in_line && !reset) begin
        checks++;
        errors++;
        $display("FAIL write_gap: fb_we 0 mid-line, required 1");
      end
      in_line = 1'b0;
    end
    if (reset) begin
      in_line  = 1'b0;
      exp_done = 1'b0;
    end
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int target;
    int n;
    int row;
    int len;

    repeat (3) @(negedge clk);
    chk("rst_fb_we", 32'(fb_we), 32'd0);
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("rst_fb_data", 32'(fb_data), 32'd0);
    chk("rst_line_done", 32'(line_done), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_err_overrun", 32'(err_overrun), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_blanked", 32'(blanked), 32'd1);
    reset = 1'b0;
    blank = 1'b0;
    repeat (4) @(negedge clk);
    chk("blanked_low", 32'(blanked), 32'd0);
    blank = 1'b1;
    repeat (4) @(negedge clk);
    chk("blanked_high", 32'(blanked), 32'd1);
    blank = 1'b0;
    repeat (4) @(negedge clk);

    // Pattern line to row 5
    for (int k = 0; k < 64; k++) begin
      logic [2:0] k3;
      k3 = 3'(k);
      drive_shift({k3, ~k3});
    end
    latch_line(5, 1'b0);
    drain();
    check_flags("t1");

    // Frame wrap 30, 31, 0
    send_line(30, 64);
    send_line(31, 64);
    send_line(0, 64);
    check_flags("t2");

    // Last shift coincides with the latch
    for (int i = 0; i < 63; i++) drive_shift(6'($urandom));
    shift_and_latch(6'($urandom), 12);
    drain();
    check_flags("coincident");

    // Second latch while the first line is still being written
    for (int i = 0; i < 64; i++) drive_shift(6'($urandom));
    latch_line(7, 1'b0);
    repeat (6) @(negedge clk);
    latch_line(8, 1'b1);
    drain();
    check_flags("t5");

    // Short line keeps stale tail columns
    send_line(3, 60);
    check_flags("t3");

    // Long line keeps the first 64 pixels
    send_line(4, 70);
    check_flags("t4");

    // Reset in the middle of a line
    target = wr_seen + 20;
    for (int i = 0; i < 64; i++) drive_shift(6'($urandom));
    latch_line(9, 1'b0);
    n = 0;
    while (wr_seen < target && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("reset_wait_timeout", 32'(n >= 500), 32'd0);
    #1 reset = 1'b1;
    @(negedge clk);
    #1 exp_q.delete();
    m_cnt         = 0;
    m_prev_valid  = 1'b0;
    m_err_count   = 1'b0;
    m_err_overrun = 1'b0;
    @(negedge clk);
    chk("t6_fb_we", 32'(fb_we), 32'd0);
    chk("t6_line_done", 32'(line_done), 32'd0);
    chk("t6_blanked", 32'(blanked), 32'd1);
    check_flags("t6_rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send_line(17, 64);
    check_flags("t6_after");

    // Randomised lines, with a forced frame wrap part way through
    for (int i = 0; i < 8; i++) begin
      row = (i == 3) ? 31 : (i == 4) ? 0 : int'($urandom_range(0, 31));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 68)) : 64;
      send_line(row, len);
    end
    check_flags("rand");

    repeat (10) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
